ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver, the successor to the basic scancode receiver. It adds:
- configurable ps2c glitch-filter length
- ps2d synchronisation
- start/stop framing check and odd-parity check
- inter-bit watchdog timeout
- first-word-fall-through scancode FIFO with a read handshake

It sits between the PS/2 pins and the keyboard decoder / typewriter logic, which pops scancodes at its own pace.

---
 rtl/ps2_rx_fifo.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 device-to-host receiver with ps2c glitch filter, framing
//               and odd-parity checks, inter-bit watchdog and an FWFT FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int FILTER_LEN   = 8,
    parameter int TIMEOUT_CYC  = 5000,
    parameter int FIFO_DEPTH   = 4,
    parameter int CHECK_PARITY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2d,
    input  logic                          ps2c,
    input  logic                          rx_en,
    input  logic                          rd_en,
    output logic [7:0]                    dout,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          rx_done_tick,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic                          busy
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_tw = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_aw:0]   c_fifo_full = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_tw-1:0] c_tmo_max   = c_tw'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_data  = 2'd1;
    localparam logic [1:0] c_st_check = 2'd2;

    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fclk;
    logic                  w_fclk_next;
    logic                  w_fall_edge;
    logic                  r_d_meta;
    logic                  r_d_sync;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [3:0]      r_bit_cnt;
    logic [c_tw-1:0] r_tmo_cnt;
    logic [9:0]      r_shift;

    logic w_start;
    logic w_shift;
    logic w_timeout;
    logic w_chk_frame_err;
    logic w_chk_parity_err;
    logic w_chk_push;

    logic       r_push_pend;
    logic [7:0] r_push_data;
    logic       r_parity_err;
    logic       r_frame_err;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_pop;
    logic            w_push;

    // Filtered clock only changes once the whole window agrees.
    always_comb begin
        w_fclk_next = r_fclk;
        if (&r_filt)
            w_fclk_next = 1'b1;
        else if (~|r_filt)
            w_fclk_next = 1'b0;
    end

    assign w_fall_edge = r_fclk & ~w_fclk_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt   <= '1;
            r_fclk   <= 1'b1;
            r_d_meta <= 1'b1;
            r_d_sync <= 1'b1;
        end else begin
            r_filt   <= {ps2c, r_filt[FILTER_LEN-1:1]};
            r_fclk   <= w_fclk_next;
            r_d_meta <= ps2d;
            r_d_sync <= r_d_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= c_st_idle;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_fall_edge && rx_en && !r_d_sync)
                    w_state_next = c_st_data;
            end
            c_st_data: begin
                if (w_fall_edge && r_bit_cnt == 4'd1)
                    w_state_next = c_st_check;
                else if (!w_fall_edge && r_tmo_cnt == c_tmo_max)
                    w_state_next = c_st_idle;
            end
            c_st_check: w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_start          = 1'b0;
        w_shift          = 1'b0;
        w_timeout        = 1'b0;
        w_chk_frame_err  = 1'b0;
        w_chk_parity_err = 1'b0;
        w_chk_push       = 1'b0;
        case (r_state)
            c_st_idle:  w_start = w_fall_edge & rx_en & ~r_d_sync;
            c_st_data: begin
                w_shift   = w_fall_edge;
                w_timeout = ~w_fall_edge & (r_tmo_cnt == c_tmo_max);
            end
            c_st_check: begin
                // r_shift = {stop, parity, data[7:0]}; odd parity means XOR is 1.
                w_chk_frame_err  = ~r_shift[9];
                w_chk_parity_err = (CHECK_PARITY != 0) & ~(^r_shift[8:0]);
                w_chk_push       = ~w_chk_frame_err & ~w_chk_parity_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= 4'd0;
            r_tmo_cnt <= '0;
            r_shift   <= '0;
        end else if (w_start) begin
            r_bit_cnt <= 4'd10;
            r_tmo_cnt <= '0;
        end else if (w_shift) begin
            r_shift   <= {r_d_sync, r_shift[9:1]};
            r_bit_cnt <= r_bit_cnt - 4'd1;
            r_tmo_cnt <= '0;
        end else if (r_state == c_st_data) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Check results are registered; the FIFO write happens in the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_push_pend  <= 1'b0;
            r_push_data  <= 8'h00;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_push_pend  <= w_chk_push;
            r_push_data  <= r_shift[7:0];
            r_parity_err <= w_chk_parity_err;
            r_frame_err  <= w_chk_frame_err | w_timeout;
        end
    end

    assign empty  = (r_count == '0);
    assign full   = (r_count == c_fifo_full);
    assign w_pop  = rd_en & ~empty;
    assign w_push = r_push_pend & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout         = empty ? 8'h00 : r_mem[r_rd_ptr];
    assign count        = r_count;
    assign rx_done_tick = w_push;
    assign overflow     = r_push_pend & full & ~w_pop;
    assign parity_err   = r_parity_err;
    assign frame_err    = r_frame_err;
    assign busy         = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Directed self-checking bench for ps2_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic       rx_en = 1'b1;
    logic       rd_en = 1'b0;
    logic       rd_en_np = 1'b0;

    logic [7:0] dout, dout_np;
    logic       empty, full, empty_np, full_np;
    logic [2:0] count, count_np;
    logic       rx_done_tick, parity_err, frame_err, overflow, busy;
    logic       rx_done_np, parity_err_np, frame_err_np, overflow_np, busy_np;

    int checks = 0;
    int failures = 0;
    int n_done = 0, n_perr = 0, n_ferr = 0, n_ovf = 0, n_busy = 0;

    ps2_rx_fifo #(.FILTER_LEN(8), .TIMEOUT_CYC(500), .FIFO_DEPTH(4), .CHECK_PARITY(1)) dut (
        .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en), .rd_en(rd_en),
        .dout(dout), .empty(empty), .full(full), .count(count), .rx_done_tick(rx_done_tick),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow), .busy(busy)
    );

    ps2_rx_fifo #(.FILTER_LEN(8), .TIMEOUT_CYC(500), .FIFO_DEPTH(4), .CHECK_PARITY(0)) dut_np (
        .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en), .rd_en(rd_en_np),
        .dout(dout_np), .empty(empty_np), .full(full_np), .count(count_np), .rx_done_tick(rx_done_np),
        .parity_err(parity_err_np), .frame_err(frame_err_np), .overflow(overflow_np), .busy(busy_np)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done_tick) n_done <= n_done + 1;
        if (parity_err)   n_perr <= n_perr + 1;
        if (frame_err)    n_ferr <= n_ferr + 1;
        if (overflow)     n_ovf  <= n_ovf + 1;
        if (busy)         n_busy <= n_busy + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {stop, parity, data, start}
    function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    function automatic logic odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic send_bits(input logic [10:0] b, input int n, input bit pop_end);
        bit seen;
        for (int i = 0; i < n; i++) begin
            ps2d = b[i];
            repeat (25) @(posedge clk);
            ps2c = 1'b0;
            if (pop_end && i == n - 1) begin
                seen = 1'b0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    if (!busy) seen = 1'b1;
                end
                checks++;
                if (!seen) begin
                    failures++;
                    $display("FAIL push_cycle_wait: busy did not drop within 50 cycles");
                end
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                repeat (40) @(posedge clk);
            end else begin
                repeat (50) @(posedge clk);
            end
            ps2c = 1'b1;
            repeat (25) @(posedge clk);
        end
        ps2d = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(mk(d, odd_par(d), 1'b1), 11, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0b exp=0", full); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rst_dout got=%02h exp=00", dout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++;
        if ({rx_done_tick, parity_err, frame_err, overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_pulses got=%04b exp=0000", {rx_done_tick, parity_err, frame_err, overflow});
        end
    endtask

    task automatic test_basic();
        int d0;
        d0 = n_done;
        send_bits(mk(8'h1C, 1'b0, 1'b1), 11, 1'b0);
        #1;
        checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", n_done - d0); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL basic_empty got=%0b exp=0", empty); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count); end
        checks++; if (dout !== 8'h1C) begin failures++; $display("FAIL basic_dout got=%02h exp=1c", dout); end
        @(posedge clk); #1;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_pop_empty got=%0b exp=1", empty); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL basic_pop_dout got=%02h exp=00", dout); end
    endtask

    task automatic test_parity();
        int d0, p0;
        do_reset();
        d0 = n_done; p0 = n_perr;
        send_bits(mk(8'h1C, 1'b1, 1'b1), 11, 1'b0);
        #1;
        checks++; if (n_perr - p0 !== 1) begin failures++; $display("FAIL par_err got=%0d exp=1", n_perr - p0); end
        checks++; if (n_done - d0 !== 0) begin failures++; $display("FAIL par_done got=%0d exp=0", n_done - d0); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL par_count got=%0d exp=0", count); end
        checks++; if (count_np !== 3'd1) begin failures++; $display("FAIL nopar_count got=%0d exp=1", count_np); end
        checks++; if (dout_np !== 8'h1C) begin failures++; $display("FAIL nopar_dout got=%02h exp=1c", dout_np); end
    endtask

    task automatic test_stop();
        int d0, f0, p0;
        do_reset();
        d0 = n_done; f0 = n_ferr; p0 = n_perr;
        send_bits(mk(8'h5A, 1'b1, 1'b0), 11, 1'b0);
        #1;
        checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL stop_ferr got=%0d exp=1", n_ferr - f0); end
        checks++; if (n_done - d0 !== 0) begin failures++; $display("FAIL stop_done got=%0d exp=0", n_done - d0); end
        checks++; if (n_perr - p0 !== 0) begin failures++; $display("FAIL stop_perr got=%0d exp=0", n_perr - p0); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL stop_count got=%0d exp=0", count); end
    endtask

    task automatic test_fifo();
        int d0, o0;
        logic [7:0] exp_b;
        do_reset();
        d0 = n_done; o0 = n_ovf;
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        #1;
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fifo_full got=%0b exp=1", full); end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fifo_count4 got=%0d exp=4", count); end
        checks++; if (n_ovf - o0 !== 0) begin failures++; $display("FAIL fifo_no_ovf got=%0d exp=0", n_ovf - o0); end
        send_byte(8'h05);
        #1;
        checks++; if (n_ovf - o0 !== 1) begin failures++; $display("FAIL fifo_ovf got=%0d exp=1", n_ovf - o0); end
        checks++; if (n_done - d0 !== 4) begin failures++; $display("FAIL fifo_done got=%0d exp=4", n_done - d0); end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fifo_count_ovf got=%0d exp=4", count); end
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            checks++; if (dout !== exp_b) begin failures++; $display("FAIL fifo_read got=%02h exp=%02h", dout, exp_b); end
            rd_en = 1'b1;
            @(posedge clk); #1;
            rd_en = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fifo_drained got=%0b exp=1", empty); end

        for (int i = 8'h11; i <= 8'h14; i++) send_byte(8'(i));
        d0 = n_done; o0 = n_ovf;
        send_bits(mk(8'h15, odd_par(8'h15), 1'b1), 11, 1'b1);
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL pushpop_count got=%0d exp=4", count); end
        checks++; if (n_ovf - o0 !== 0) begin failures++; $display("FAIL pushpop_ovf got=%0d exp=0", n_ovf - o0); end
        checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL pushpop_done got=%0d exp=1", n_done - d0); end
        checks++; if (dout !== 8'h12) begin failures++; $display("FAIL pushpop_dout got=%02h exp=12", dout); end
    endtask

    task automatic test_timeout();
        int d0, f0, p0;
        do_reset();
        d0 = n_done; f0 = n_ferr; p0 = n_perr;
        send_bits(mk(8'hA5, 1'b1, 1'b1), 5, 1'b0);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tmo_busy_mid got=%0b exp=1", busy); end
        repeat (600) @(posedge clk);
        #1;
        checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL tmo_ferr got=%0d exp=1", n_ferr - f0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%0b exp=0", busy); end
        checks++; if (n_done - d0 !== 0) begin failures++; $display("FAIL tmo_done got=%0d exp=0", n_done - d0); end
        send_bits(mk(8'hF0, 1'b1, 1'b1), 11, 1'b0);
        #1;
        checks++; if (dout !== 8'hF0) begin failures++; $display("FAIL tmo_next_dout got=%02h exp=f0", dout); end
        checks++; if (n_ferr - f0 !== 1 || n_perr - p0 !== 0) begin
            failures++; $display("FAIL tmo_next_errs got=f%0d/p%0d exp=f1/p0", n_ferr - f0, n_perr - p0);
        end
    endtask

    task automatic test_rx_en();
        int d0;
        do_reset();
        d0 = n_done;
        rx_en = 1'b0;
        send_byte(8'h1C);
        rx_en = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rxen_count got=%0d exp=0", count); end
        checks++; if (n_done - d0 !== 0) begin failures++; $display("FAIL rxen_done got=%0d exp=0", n_done - d0); end
    endtask

    task automatic test_glitch_reset();
        int b0;
        do_reset();
        b0 = n_busy;
        ps2d = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ps2c = 1'b0;
            repeat (3) @(posedge clk);
            ps2c = 1'b1;
            repeat (20) @(posedge clk);
        end
        ps2d = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (n_busy - b0 !== 0) begin failures++; $display("FAIL glitch_busy got=%0d cycles exp=0", n_busy - b0); end

        send_byte(8'h22);
        send_byte(8'h33);
        #1;
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=2", count); end
        send_bits(mk(8'h44, odd_par(8'h44), 1'b1), 7, 1'b0);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre_busy got=%0b exp=1", busy); end
        do_reset();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%0b exp=1", empty); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        checks++;
        if ({rx_done_tick, parity_err, frame_err, overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_pulses got=%04b exp=0000", {rx_done_tick, parity_err, frame_err, overflow});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop();
        test_fifo();
        test_timeout();
        test_rx_en();
        test_glitch_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
